// File: rtl/proc_pkg.sv
// Shared definitions for the parametrised lab processor: opcodes, step encoding,
// instruction field positions and the ALU operation select.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  localparam int IR_W     = 9;
  localparam int IR_I_MSB = 8;
  localparam int IR_I_LSB = 6;
  localparam int IR_X_MSB = 5;
  localparam int IR_X_LSB = 3;
  localparam int IR_Y_MSB = 2;
  localparam int IR_Y_LSB = 0;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } step_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10
  } alu_op_t;

  function automatic alu_op_t alu_op_of(input logic [2:0] opcode);
    case (opcode)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational W-bit ALU: add, subtract (a-b) and bitwise AND, modulo 2^W,
// plus a zero flag on the result.
module proc_alu
  import proc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_op_t      op,
  output logic [W-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/proc_core_n.sv
// Multi-step processor with NREG registers on a shared W-bit bus, stepped T0..T3.
// Optional macro PROC_ZFLAG_EN adds a zero flag and turns opcode 101 into mvnz.
module proc_core_n
  import proc_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [W-1:0] DIN,
  input  logic         Run,
  output logic         Done,
  output logic [W-1:0] BusWires
);

  step_t            step_q, step_d;
  logic [IR_W-1:0]  ir_q;
  logic [W-1:0]     a_q, g_q;
  logic [W-1:0]     r_q [8];

  logic [2:0]       opcode, x_idx, y_idx;
  logic [W-1:0]     rx_val, ry_val;
  logic [W-1:0]     alu_res, wdata;
  logic             alu_zero;
  logic             ir_load, a_load, g_load, r_we;

  assign opcode = ir_q[IR_I_MSB:IR_I_LSB];
  assign x_idx  = ir_q[IR_X_MSB:IR_X_LSB];
  assign y_idx  = ir_q[IR_Y_MSB:IR_Y_LSB];

  // Indices at or above NREG read as zero; those entries are never written.
  assign rx_val = (int'(x_idx) < NREG) ? r_q[x_idx] : '0;
  assign ry_val = (int'(y_idx) < NREG) ? r_q[y_idx] : '0;

  proc_alu #(.W(W)) u_alu (
    .a      (a_q),
    .b      (ry_val),
    .op     (alu_op_of(opcode)),
    .result (alu_res),
    .zero   (alu_zero)
  );

`ifdef PROC_ZFLAG_EN
  logic z_q;
  always_ff @(posedge Clock) begin
    if (!Resetn)     z_q <= 1'b1;
    else if (g_load) z_q <= alu_zero;
  end
`else
  logic zero_unused;
  assign zero_unused = alu_zero;
`endif

  always_comb begin
    step_d   = step_q;
    Done     = 1'b0;
    BusWires = '0;
    wdata    = '0;
    ir_load  = 1'b0;
    a_load   = 1'b0;
    g_load   = 1'b0;
    r_we     = 1'b0;
    case (step_q)
      T0: begin
        if (Run) begin
          BusWires = DIN;
          ir_load  = 1'b1;
          step_d   = T1;
        end
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            BusWires = ry_val;
            wdata    = ry_val;
            r_we     = 1'b1;
            Done     = 1'b1;
            step_d   = T0;
          end
          OP_MVI: begin
            BusWires = DIN;
            wdata    = DIN;
            r_we     = 1'b1;
            Done     = 1'b1;
            step_d   = T0;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            BusWires = rx_val;
            a_load   = 1'b1;
            step_d   = T2;
          end
`ifdef PROC_ZFLAG_EN
          OP_MVNZ: begin
            // Conditional move bypasses the bus; only the write is gated.
            wdata  = ry_val;
            r_we   = ~z_q;
            Done   = 1'b1;
            step_d = T0;
          end
`endif
          default: begin
            Done   = 1'b1;
            step_d = T0;
          end
        endcase
      end
      T2: begin
        BusWires = ry_val;
        g_load   = 1'b1;
        step_d   = T3;
      end
      T3: begin
        BusWires = g_q;
        wdata    = g_q;
        r_we     = 1'b1;
        Done     = 1'b1;
        step_d   = T0;
      end
      default: step_d = T0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      step_q <= T0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
    end else begin
      step_q <= step_d;
      if (ir_load) ir_q <= DIN[IR_W-1:0];
      if (a_load)  a_q  <= BusWires;
      if (g_load)  g_q  <= alu_res;
      if (r_we && (int'(x_idx) < NREG)) r_q[x_idx] <= wdata;
    end
  end

endmodule

// File: doc/proc_core_n.md
# proc_core_n

Parametrised successor to the two-register lab processor. It executes a 9-bit instruction stream fetched from `DIN` over a shared internal bus, using a 2-bit step counter. The block generalises data width and register count, and adds AND and NOP instructions plus an optional conditional move. It sits between the instruction memory/address counter and the board I/O (`LEDR` shows `BusWires` and `Done`).

## Interface
Parameters:
- `W`, default 16: data and bus width. Legal range is 9 to 32.
- `NREG`, default 8: number of general registers R0..R(NREG-1). Legal range is 2 to 8.

Ports:
- `Clock`  in  1: single clock. All state updates on the rising edge.
- `Resetn`  in  1: reset is synchronous and active-low.
- `DIN`  in  W: instruction word, or immediate word during `mvi` T1.
- `Run`  in  1: start request, sampled only in T0.
- `Done`  out  1: high during the final step of an instruction.
- `BusWires`  out  W: current internal bus value.

## Operation
- Instruction fields: `IR[8:6]` = I (opcode), `IR[5:3]` = X, `IR[2:0]` = Y. Bits of `DIN` above bit 8 are ignored for instructions.
- Register indices ≥ NREG: reads return 0, writes are dropped.
- Steps T0..T3 are tracked by a step counter.
  - T0: if `Run`=1, IR ← `DIN[8:0]` and advance to T1. Otherwise stay in T0 and IR holds.
- Opcode 000 `mv`: in T1, Rx ← Ry and `Done`=1.
- Opcode 001 `mvi`: in T1, Rx ← `DIN` and `Done`=1.
- Opcodes 010 `add`, 011 `sub`, 100 `and`:
  - T1: A ← Rx.
  - T2: G ← A+Ry, A−Ry or A&Ry respectively.
  - T3: Rx ← G and `Done`=1.
- Opcodes 101 (without macro), 110, 111: NOP. `Done`=1 in T1 and nothing is written.
- Arithmetic is modulo 2^W; carry and borrow are discarded. `sub` computes Rx−Ry.
- Bus source priority is exactly one of: `DIN` (T0 and mvi T1), Ry (mv T1, ALU T2), Rx (ALU T1), G (ALU T3). In every other case the bus drives 0.
- After a `Done` step, the next edge returns the counter to T0.
- `Run` is ignored outside T0. Back-to-back instructions require `Run` high in T0.

## Timing
- Reset (Resetn=0 at an edge):
  - Next state: step T0, IR=0, A=0, G=0, all Rn=0, Z=1 if the macro is enabled.
  - Outputs: `Done`=0, `BusWires`=0 whenever in T0 with `Run`=0.
- Reset mid-instruction aborts it. No register write occurs at that edge.
- `Done` and `BusWires` are combinational from step, IR and registers. They are valid within the same cycle.
- Latency, counted from the edge that loads IR:
  - mv, mvi and NOP complete at the next edge (2 cycles including T0).
  - ALU ops complete at the third edge (4 cycles including T0).
- `mvi`: the immediate word must be present on `DIN` throughout T1.
- Simultaneous Rx write and Ry read in the same step: the old value is read and the new value is written at the edge.

## Configuration
- `PROC_ZFLAG_EN` defined:
  - Adds a Z flag register. Z ← (ALU result == 0) whenever G loads in T2.
  - Opcode 101 becomes `mvnz`: in T1, if Z=0 then Rx ← Ry, else no write. `Done`=1 in either case.
- `PROC_ZFLAG_EN` undefined: no Z register is built, and 101 is a NOP.

## Structure
- Shared package `proc_pkg` holds:
  - opcode localparams: `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_MVNZ`;
  - the step encoding: T0=00, T1=01, T2=10, T3=11;
  - the IR field positions.
- One sub-module, `proc_alu`: combinational, W-parametrised, with inputs A, B and a 2-bit op (add/sub/and), and outputs result and zero.
- The register file, step counter and control decode stay in `proc_core_n`.

## Test plan
All scenarios use W=16, NREG=8.
- Reset, then `mvi R0,#5` (DIN=0x0040, then 0x0005 in T1) → `Done`=1 in T1; R0=0x0005; bus shows 0x0005 in T1.
- R0=5, R1=3; `add R0,R1` (0x0081) → `Done` only in T3; R0=0x0008; G=0x0008 after T2.
- R0=3, R1=5; `sub R0,R1` → R0=0xFFFE (wrap-around); R1 unchanged.
- R2=0x00F0, R3=0x0FF0; `and R2,R3` → R2=0x00F0. Then `mv R4,R2` → R4=0x00F0 in 2 cycles.
- `Resetn`=0 during T2 of an `add` → next cycle step=T0; all regs 0; `Done`=0; no partial write.
- With `PROC_ZFLAG_EN`:
  - `sub R0,R0` (Z=1), then `mvnz R1,R2` → R1 unchanged.
  - `add` with a nonzero result, then `mvnz R1,R2` → R1=R2.
  - Without the macro, opcode 101 → NOP with `Done` in T1.
